// File: rtl/ram_loader_8x12.sv
// Serial-to-parallel RAM loader: shifts WIDTH-bit words in MSB first and
// writes 2**AW of them into a small RAM that has a combinational tri-state read port.
module ram_loader_8x12 #(
  parameter int WIDTH = 12,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SDI,
  input  logic             SDV,
  input  logic             CS,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [WIDTH-1:0] DATA,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [3:0]    LAST_BIT  = 4'(WIDTH - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'((2 ** AW) - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en;

  logic [WIDTH-1:0] mem [2**AW];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE, FULL: begin
        if (START) begin
          state_d = SHIFT;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (SDV) begin
          shreg_d = {shreg_q[WIDTH-2:0], SDI};
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      WRITE: begin
        // Any serial bit offered during this cycle is intentionally dropped.
        wr_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = FULL;
        end else begin
          state_d = SHIFT;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT) || (state_d == WRITE);
    done_d = (state_d == FULL);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Storage is deliberately left out of reset so a mid-load reset keeps completed words.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[addr_q] <= shreg_q;
    end
  end

  assign DATA = CS ? mem[RD_ADDR] : {WIDTH{1'bz}};
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_ram_loader_8x12.sv
// Directed self-checking bench for ram_loader_8x12: full loads, reload with
// START held, SDV gaps, read-during-write, mid-sequence reset.
module tb_ram_loader_8x12;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        SDI;
  logic        SDV;
  logic        CS;
  logic [2:0]  RD_ADDR;
  wire  [11:0] DATA;
  logic        BUSY;
  logic        DONE;

  int testsRun    = 0;
  int testsFailed = 0;
  int busyCount   = 0;

  logic [11:0] setA [8] = '{12'h001, 12'h123, 12'h245, 12'h367,
                            12'h489, 12'h5AB, 12'h6CD, 12'h7FF};
  logic [11:0] setB [8] = '{12'hFFF, 12'h800, 12'h0AA, 12'h555,
                            12'h3C3, 12'hC3C, 12'hF0F, 12'h0F0};
  logic [11:0] setC [5] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};

  ram_loader_8x12 #(.WIDTH(12), .AW(3)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .SDI     (SDI),
    .SDV     (SDV),
    .CS      (CS),
    .RD_ADDR (RD_ADDR),
    .DATA    (DATA),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge; tally BUSY.
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
    if (BUSY) busyCount++;
  endtask

  task automatic shiftBits(input logic [11:0] w);
    for (int b = 11; b >= 0; b--) begin
      SDV = 1'b1;
      SDI = w[b];
      applyStimulus();
    end
    SDV = 1'b0;
    SDI = 1'b0;
  endtask

  task automatic loadWord(input logic [11:0] w);
    shiftBits(w);
    applyStimulus();
  endtask

  task automatic readWord(input string tag, input logic [2:0] a, input logic [11:0] exp);
    CS      = 1'b1;
    RD_ADDR = a;
    #1;
    checkOutput(tag, {20'd0, DATA}, {20'd0, exp});
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; SDI = 1'b0; SDV = 1'b0; CS = 1'b0; RD_ADDR = '0;
    #12;
    checkOutput("resetBusy", {31'd0, BUSY}, 32'd0);
    checkOutput("resetDone", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Full load of set A with continuous SDV between WRITE slots.
    START = 1'b1;
    busyCount = 0;
    applyStimulus();
    START = 1'b0;
    checkOutput("startBusy", {31'd0, BUSY}, 32'd1);
    for (int w = 0; w < 8; w++) loadWord(setA[w]);
    checkOutput("busyCycles", busyCount, 32'd104);
    checkOutput("fullDone", {31'd0, DONE}, 32'd1);
    checkOutput("fullBusy", {31'd0, BUSY}, 32'd0);
    for (int a = 0; a < 8; a++) readWord($sformatf("readA%0d", a), 3'(a), setA[a]);

    CS = 1'b0;
    RD_ADDR = 3'd7;
    #1;
    checkOutput("csLowUndriven", {31'd0, (DATA !== 12'h7FF)}, 32'd1);

    // Reload from FULL with START held high for the whole sequence.
    START = 1'b1;
    applyStimulus();
    checkOutput("reloadBusy", {31'd0, BUSY}, 32'd1);
    checkOutput("reloadDoneLow", {31'd0, DONE}, 32'd0);
    for (int w = 0; w < 3; w++) loadWord(setB[w]);
    shiftBits(setB[3]);
    readWord("rdwOld", 3'd3, 12'h367);
    applyStimulus();
    readWord("rdwNew", 3'd3, 12'h555);
    for (int w = 4; w < 7; w++) loadWord(setB[w]);
    checkOutput("heldStartBusy", {31'd0, BUSY}, 32'd1);
    loadWord(setB[7]);
    checkOutput("reloadDone", {31'd0, DONE}, 32'd1);
    checkOutput("reloadFullBusy", {31'd0, BUSY}, 32'd0);
    applyStimulus();
    checkOutput("doneOneCycle", {31'd0, DONE}, 32'd0);
    checkOutput("restartBusy", {31'd0, BUSY}, 32'd1);
    START = 1'b0;
    for (int a = 0; a < 8; a++) readWord($sformatf("readB%0d", a), 3'(a), setB[a]);

    // Gappy SDV load of 0xA5C into word 0; the idle-cycle SDI must be ignored.
    for (int b = 11; b >= 0; b--) begin
      SDV = 1'b1;
      SDI = (12'hA5C >> b) & 1'b1;
      applyStimulus();
      SDV = 1'b0;
      SDI = ~SDI;
      if (b != 0) applyStimulus();
    end
    checkOutput("gapBusy", {31'd0, BUSY}, 32'd1);
    SDV = 1'b1;
    SDI = 1'b1;
    applyStimulus();
    SDV = 1'b0;
    readWord("gapWord", 3'd0, 12'hA5C);
    loadWord(12'h9E1);
    readWord("oneWrite", 3'd1, 12'h9E1);
    readWord("word2Kept", 3'd2, 12'h0AA);

    // Reset mid-sequence: 5 words plus 6 bits of word 5.
    @(negedge CLK);
    RST_N = 1'b0;
    #2;
    @(negedge CLK);
    RST_N = 1'b1;
    START = 1'b1;
    applyStimulus();
    START = 1'b0;
    checkOutput("firstStartBusy", {31'd0, BUSY}, 32'd1);
    for (int w = 0; w < 5; w++) loadWord(setC[w]);
    for (int b = 0; b < 6; b++) begin
      SDV = 1'b1;
      SDI = 1'b1;
      applyStimulus();
    end
    SDV = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'd0, BUSY}, 32'd0);
    checkOutput("midResetDone", {31'd0, DONE}, 32'd0);
    for (int a = 0; a < 5; a++) readWord($sformatf("readC%0d", a), 3'(a), setC[a]);
    readWord("word5Kept", 3'd5, 12'hC3C);
    CS = 1'b0;
    #1;
    checkOutput("csLowInReset", {31'd0, (DATA !== 12'hC3C)}, 32'd1);
    applyStimulus();
    checkOutput("resetHoldsIdle", {31'd0, BUSY}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
